// File: rtl/argmax_pkg.sv
// Shared types and width helpers for the argmax classifier decision stage.
package argmax_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

  // Index width for an N-element vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_out_8.sv
// Streams an N-element signed score vector and reports the index and value
// of its maximum on a valid/ready result port (earliest index wins ties).
module argmax_out_8
  import argmax_pkg::*;
#(
  parameter int N = 8,
  parameter int T = 8,
  localparam int IW = idx_width(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [IW-1:0]       output_index,
  output logic signed [T-1:0] output_max
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  argmax_state_t       r_state;
  logic [IW-1:0]       r_count;
  logic [IW-1:0]       r_idx;
  logic signed [T-1:0] r_max;
  logic                r_in_ready;
  logic                r_out_valid;

  logic w_accept;
  assign w_accept = input_valid && r_in_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; the reset branch is in the sensitivity list, making it async.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= SCAN;
          r_in_ready <= 1'b1;
        end
        SCAN: begin
          if (w_accept) begin
            // Strict '>' keeps the lower index on ties.
            if (r_count == '0 || input_data > r_max) begin
              r_max <= input_data;
              r_idx <= r_count;
            end
            if (r_count == LAST) begin
              r_count     <= '0;
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DONE: begin
          if (output_ready) begin
            r_state     <= SCAN;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign input_ready  = r_in_ready;
  assign output_valid = r_out_valid;
  assign output_index = r_idx;
  assign output_max   = r_max;

endmodule
